// File: rtl/opl_reg_write_ctrl_if.sv
// ============================================================================
// opl_reg_write_ctrl_if: host write/read-back bus of the OPL register writer.
// Rev 1.0
// ============================================================================
`default_nettype none

interface opl_reg_write_ctrl_if #(
   parameter int ADDR_W = 9
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;

   modport master (
      output wr_valid, wr_addr, wr_data, rd_addr,
      input  wr_ready, rd_data
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_addr,
      output wr_ready, rd_data
   );
endinterface

`default_nettype wire

// File: rtl/opl_reg_write_ctrl.sv
// ============================================================================
// opl_reg_write_ctrl: queues host writes and commits them into the OPL register image.
// Rev 1.0
// ============================================================================
`default_nettype none

module opl_reg_write_ctrl #(
   parameter  int NUM_BANKS  = 2,
   parameter  int FIFO_DEPTH = 8,
   localparam int ADDR_W     = 8 + $clog2(NUM_BANKS)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           sample_clk_en,
   opl_reg_write_ctrl_if.slave            bus,
   output logic [NUM_BANKS*256-1:0][7:0]  opl_reg,
   output logic                           irq_rst_pulse,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic                           busy
);

   localparam int                c_PTR_W    = $clog2(FIFO_DEPTH);
   localparam int                c_LVL_W    = c_PTR_W + 1;
   localparam logic [ADDR_W-1:0] c_IRQ_ADDR = ADDR_W'(4);

   logic [ADDR_W-1:0]              r_q_addr [FIFO_DEPTH];
   logic [7:0]                     r_q_data [FIFO_DEPTH];
   logic [c_PTR_W-1:0]             r_wr_ptr;
   logic [c_PTR_W-1:0]             r_rd_ptr;
   logic [c_LVL_W-1:0]             r_level;
   logic [c_LVL_W-1:0]             w_level_nxt;
   logic                           r_busy;
   logic                           r_irq;
   logic [7:0]                     r_rd_data;
   logic [NUM_BANKS*256-1:0][7:0]  r_opl_reg;

   logic                           w_push;
   logic                           w_pop;
   logic [ADDR_W-1:0]              w_head_addr;
   logic [7:0]                     w_head_data;
   logic                           w_irq_hit;
   logic [7:0]                     w_commit_data;

   // Ready depends only on registered occupancy, never on wr_valid.
   assign bus.wr_ready  = (r_level != c_LVL_W'(FIFO_DEPTH));
   assign bus.rd_data   = r_rd_data;
   assign opl_reg       = r_opl_reg;
   assign irq_rst_pulse = r_irq;
   assign fifo_level    = r_level;
   assign busy          = r_busy;

   assign w_push        = bus.wr_valid && bus.wr_ready;
   assign w_pop         = r_busy && !sample_clk_en;
   assign w_head_addr   = r_q_addr[r_rd_ptr];
   assign w_head_data   = r_q_data[r_rd_ptr];
   assign w_irq_hit     = (w_head_addr == c_IRQ_ADDR) && w_head_data[7];
   assign w_commit_data = w_irq_hit ? {1'b0, w_head_data[6:0]} : w_head_data;

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + c_LVL_W'(1);
      end else if (w_pop && !w_push) begin
         w_level_nxt = r_level - c_LVL_W'(1);
      end
   end

   // Queue storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_addr[r_wr_ptr] <= bus.wr_addr;
         r_q_data[r_wr_ptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_busy    <= 1'b0;
         r_irq     <= 1'b0;
         r_rd_data <= 8'h00;
         r_opl_reg <= '0;
      end else begin
         r_level   <= w_level_nxt;
         r_busy    <= (w_level_nxt != '0);
         r_irq     <= w_pop && w_irq_hit;
         // Read-back samples the image before any commit on this edge.
         r_rd_data <= r_opl_reg[bus.rd_addr];
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr               <= r_rd_ptr + c_PTR_W'(1);
            r_opl_reg[w_head_addr] <= w_commit_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/opl_reg_write_ctrl.md
OPL_REG_WRITE_CTRL -- requirements
Module: opl_reg_write_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BANKS, default 2, number of 256-byte register banks; legal values 1, 2, 4.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, host write queue depth; power of two, 2..64.
REQ-003 The block SHALL have derived localparam ADDR_W = 8+$clog2(NUM_BANKS), the register address width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port sample_clk_en, input, 1 bit: one-cycle sample strobe.
REQ-007 The block SHALL have port wr_valid, input, 1 bit: host write request.
REQ-008 The block SHALL have port wr_ready, output, 1 bit: queue can accept.
REQ-009 The block SHALL have port wr_addr, input, ADDR_W bits: register address, bank = upper bits.
REQ-010 The block SHALL have port wr_data, input, 8 bits: register write data.
REQ-011 The block SHALL have port rd_addr, input, ADDR_W bits: read-back address.
REQ-012 The block SHALL have port rd_data, output, 8 bits: read-back data.
REQ-013 The block SHALL have port opl_reg, output, [NUM_BANKS*256] x 8 bits: committed register image, feeding the decode stage.
REQ-014 The block SHALL have port irq_rst_pulse, output, 1 bit: timer flag reset strobe.
REQ-015 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: queue occupancy.
REQ-016 The block SHALL have port busy, output, 1 bit: queue non-empty.

Function
REQ-017 A write SHALL be accepted on a rising edge where wr_valid=1 and wr_ready=1; wr_ready SHALL equal (fifo_level != FIFO_DEPTH), with no combinational path from wr_valid.
REQ-018 While wr_valid=1 and wr_ready=0, the host SHALL hold wr_addr and wr_data; the block SHALL NOT drop or duplicate any accepted write.
REQ-019 Accepted writes SHALL be queued in FIFO order with storage depth FIFO_DEPTH.
REQ-020 On each cycle with busy=1 and sample_clk_en=0, the head entry SHALL be committed to opl_reg and popped; at most one commit SHALL occur per cycle.
REQ-021 On a cycle with sample_clk_en=1, no commit SHALL occur, so opl_reg is stable when downstream samples it.
REQ-022 Minimum latency SHALL be: a write accepted at edge N with an empty queue is visible on opl_reg after edge N+1, provided sample_clk_en=0 in the cycle before N+1.
REQ-023 Push and pop in the same cycle SHALL leave fifo_level unchanged; when full, a pop SHALL NOT free wr_ready until the following cycle.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 A commit to address 0x004 (bank 0) with data bit7=1 SHALL assert irq_rst_pulse for exactly one cycle, coincident with opl_reg update, and SHALL store data with bit7 cleared; bits 6:0 SHALL be stored unchanged.
REQ-026 A commit to address 0x004 with bit7=0 SHALL store data as-is with no pulse; commits to other addresses, including bank 1 offset 0x004, SHALL store as-is with no pulse.
REQ-027 rd_data SHALL be registered: value of opl_reg[rd_addr] as of the edge, with one-cycle latency; a same-cycle commit to rd_addr SHALL return the pre-commit value.
REQ-028 busy SHALL equal (fifo_level != 0), registered.

Reset
REQ-029 When reset_n=0, asynchronously: all opl_reg bytes = 0x00, queue empty, fifo_level = 0, busy = 0, irq_rst_pulse = 0, rd_data = 0x00.
REQ-030 wr_ready SHALL be 1 from the first edge after reset_n deasserts.
REQ-031 Reset mid-operation SHALL discard all queued, uncommitted writes, with no partial commit.

Verification
REQ-032 Scenario: reset, then write 0x1A0=0x55 with sample_clk_en=0 -> opl_reg[0x1A0]=0x55 one edge after accept; rd_addr=0x1A0 returns 0x55 on the next cycle.
REQ-033 Scenario: burst of 10 writes with FIFO_DEPTH=8 and sample_clk_en held 1 -> wr_ready falls after 8 accepts, fifo_level=8, no opl_reg change; release strobe -> 10 writes committed in order, final level 0.
REQ-034 Scenario: write 0x004=0xE3 -> irq_rst_pulse high one cycle, opl_reg[0x004]=0x63; write 0x104=0x80 -> stored 0x80, no pulse.
REQ-035 Scenario: two writes to 0x0B0 (0x20 then 0x00) -> opl_reg[0x0B0] shows 0x20 for one commit cycle, then 0x00; no reordering.
REQ-036 Scenario: 5 queued writes, reset_n pulsed low -> opl_reg all zero, fifo_level=0, none of the 5 appear after release.
REQ-037 Scenario: NUM_BANKS=4 build, write 0x3FF=0xAA -> opl_reg[1023]=0xAA; the other banks are unchanged.
